mips_multicycle_cpu: RTL
========================

Name: mips_multicycle_cpu

Overview:
Parametrised multi-cycle successor to the single-cycle 16-bit MIPS-subset CPU. It runs the same 16-bit instruction encoding as a FETCH/DECODE/EXEC/MEM/WB state machine. It adds load/store with an internal data memory, BEQ/BNE branches, HALT, a hardwired-zero r0 and a configurable datapath width. Instruction memory is external; the core is the top-level compute block under the testbench.

Parameters:
WIDTH, 16, datapath/register/PC width in bits; legal range 16..64.
DMEM_DEPTH, 256, data memory words; power of two.

Ports:
clock  input  1  single clock; all state updates on posedge.
reset  input  1  asynchronous, active-high; clears all architectural state.
imem_addr  output  WIDTH  byte address of the next instruction (= PC).
imem_data  input  16  instruction word at imem_addr; combinational read.
ir  output  16  current instruction register.
alu_out  output  WIDTH  registered ALU result.
state  output  3  current FSM state encoding.
retire  output  1  one-cycle pulse in the final cycle of each instruction.
halted  output  1  high once HALT has executed; stays high until reset.

Behaviour:
- Encoding: op=IR[15:12], rs=IR[11:10], rt=IR[9:8], rd=IR[7:6], imm=IR[7:0], sign-extended to WIDTH.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 7 SLT (signed): R-type, rd = rs op rt.
  - 4 ADDI: rt = rs + imm.
  - 5 LW: rt = M[rs+imm].
  - 6 SW: M[rs+imm] = rt.
  - 8 BEQ, 9 BNE.
  - 15 HALT.
  - All other opcodes are NOPs.
- Registers: 4 x WIDTH. r0 reads 0 and ignores writes.
- Arithmetic wraps mod 2^WIDTH, with no overflow flag. SLT result is 1 or 0, zero-extended.
- PC is a byte address that increments by 2. Branch target = PC+2 + (imm<<1), wrapping mod 2^WIDTH.
- Data memory: word index = (addr>>1) mod DMEM_DEPTH; addr bit 0 is ignored. Contents are not reset.
- FSM states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
  - FETCH: IR<=imem_data; PC<=PC+2; go to DECODE.
  - DECODE: A<=R[rs], B<=R[rt]. HALT opcode goes to HALT; everything else goes to EXEC.
  - EXEC:
    - ALU/ADDI: alu_out<=result, go to WB.
    - LW/SW: alu_out<=A+imm, go to MEM.
    - BEQ/BNE: if taken, PC<=target; go to FETCH.
    - NOP: go to FETCH.
  - MEM: LW latches MDR<=M[idx] and goes to WB. SW writes M[idx]<=B and goes to FETCH.
  - WB: ALU ops write rd<=alu_out; ADDI writes rt<=alu_out; LW writes rt<=MDR. Go to FETCH.
  - HALT: absorbing; PC and registers frozen; halted=1.
- Latency in cycles: R/ADDI 4, LW 5, SW 4, BEQ/BNE/NOP 3, HALT 2 (then parks).
- retire=1 in the last cycle of each instruction (WB, SW's MEM, branch/NOP EXEC), and in the DECODE cycle of HALT.
- Reset values: PC=0, IR=0, alu_out=0, A=B=MDR=0, regs=0, state=FETCH, retire=0, halted=0.
- Reset asserted mid-instruction aborts it: no partial register write. A store is not performed unless its MEM edge has already occurred.
- Instruction writing its own source register: sources are read in DECODE, so the old value is used.
- Branch with offset -1 targets itself (tight loop); this is legal.

Decomposition:
- Package mips_pkg: opcode localparams, FSM state encodings, ALU control codes (ADD, SUB, AND, OR, SLT) and an opcode-to-ALU-control function.
- Sub-module mips_alu_w, parameter WIDTH: combinational a, b, ctl -> result, zero. Two instances are not needed; PC+2 and the branch target use plain adders in the core.

Test Plan:
- Seven-instruction ALU program: ADDI r1=15; ADDI r2=7; AND r3=r1&r2 (7); SUB r2=r1-r3 (8); OR r2=r2|r3 (15); ADD r3=r2+r3 (22); SLT r1=r3<r2 (0). Then HALT -> final r1=0, r2=15, r3=22; 7 retire pulses over 28 cycles, plus one at HALT DECODE (cycle 30); halted=1.
- ADDI r1=0x12; SW r1,4(r0); LW r2,4(r0); HALT -> M[2]=0x12, r2=0x12; the LW takes exactly 5 cycles.
- Countdown: r1=3; loop ADDI r1,-1; BNE r1,r0,-2 -> loop body executes 3 times, then falls through, r1=0. A BEQ with unequal operands -> PC advances by 2 only.
- ADDI r0,5 then ADD r1,r0,r0 -> r1=0 (r0 stays zero). ADDI r1=-1 (0xFFFF), ADD r1,r1,r1 -> 0xFFFE (wrap). SLT of -1 < 1 -> 1.
- Assert reset during LW's MEM cycle -> state=FETCH, PC=0, r2 unchanged at 0, halted=0; the program then reruns correctly.
- WIDTH=32, DMEM_DEPTH=16: ADDI r1=-128 -> r1=0xFFFFFF80. SW to address 40 -> stored in word 4 (index wraps mod 16).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle 16-bit-encoding MIPS subset core:
// opcodes, FSM state encodings, ALU controls and opcode classification helpers.
package mips_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctl_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SLT);
  endfunction

  function automatic logic uses_imm(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // Branches compare by subtraction so the ALU zero flag decides them.
  function automatic alu_ctl_t alu_ctl_of(input logic [3:0] op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE: return ALU_SUB;
      OP_AND:                 return ALU_AND;
      OP_OR:                  return ALU_OR;
      OP_SLT:                 return ALU_SLT;
      default:                return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu_w.sv
// Combinational WIDTH-bit ALU: add, sub, and, or, signed set-less-than.
module mips_alu_w
  import mips_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_ctl_t         ctl,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = '0;
    case (ctl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB FSM, 4 registers with
// hardwired r0, internal data memory, external combinational instruction memory.
module mips_multicycle_cpu
  import mips_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DMEM_DEPTH = 256
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [15:0]      imem_data,
  output logic [15:0]      ir,
  output logic [WIDTH-1:0] alu_out,
  output logic [2:0]       state,
  output logic             retire,
  output logic             halted
);

  localparam int AW = $clog2(DMEM_DEPTH);

  state_t           state_reg;
  logic [WIDTH-1:0] pc_reg;
  logic [15:0]      ir_reg;
  logic [WIDTH-1:0] a_reg, b_reg, mdr_reg, alu_reg;
  logic             retire_reg, halted_reg;
  logic [WIDTH-1:0] regs [4];
  logic [WIDTH-1:0] dmem [DMEM_DEPTH];

  logic [3:0]       op;
  logic [1:0]       rs, rt, rd;
  logic [WIDTH-1:0] imm_ext, alu_b, alu_result, rs_val, rt_val, branch_target;
  logic             alu_zero, taken;
  alu_ctl_t         alu_ctl;
  logic [AW-1:0]    dmem_idx;
  logic             wb_en;
  logic [1:0]       wb_dst;
  logic [WIDTH-1:0] wb_val;

  assign op = ir_reg[15:12];
  assign rs = ir_reg[11:10];
  assign rt = ir_reg[9:8];
  assign rd = ir_reg[7:6];
  assign imm_ext = {{(WIDTH-8){ir_reg[7]}}, ir_reg[7:0]};

  assign rs_val = (rs == 2'd0) ? '0 : regs[rs];
  assign rt_val = (rt == 2'd0) ? '0 : regs[rt];

  assign alu_ctl = alu_ctl_of(op);
  assign alu_b   = uses_imm(op) ? imm_ext : b_reg;

  mips_alu_w #(.WIDTH(WIDTH)) u_alu (
    .a      (a_reg),
    .b      (alu_b),
    .ctl    (alu_ctl),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // pc_reg already holds PC+2 once the instruction has been fetched.
  assign branch_target = pc_reg + {imm_ext[WIDTH-2:0], 1'b0};
  assign taken         = (op == OP_BEQ) ? alu_zero : !alu_zero;
  assign dmem_idx      = alu_reg[AW:1];

  always_comb begin
    wb_en  = 1'b0;
    wb_dst = rd;
    wb_val = alu_reg;
    if (is_alu_op(op)) begin
      wb_en = 1'b1;
    end else if (op == OP_ADDI) begin
      wb_en  = 1'b1;
      wb_dst = rt;
    end else if (op == OP_LW) begin
      wb_en  = 1'b1;
      wb_dst = rt;
      wb_val = mdr_reg;
    end
    if (wb_dst == 2'd0) wb_en = 1'b0;
  end

  // retire_reg is set on the edge entering an instruction's final cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= S_FETCH;
      pc_reg     <= '0;
      ir_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      mdr_reg    <= '0;
      alu_reg    <= '0;
      retire_reg <= 1'b0;
      halted_reg <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      retire_reg <= 1'b0;
      case (state_reg)
        S_FETCH: begin
          ir_reg     <= imem_data;
          pc_reg     <= pc_reg + WIDTH'(2);
          retire_reg <= (imem_data[15:12] == OP_HALT);
          state_reg  <= S_DECODE;
        end
        S_DECODE: begin
          a_reg <= rs_val;
          b_reg <= rt_val;
          if (op == OP_HALT) begin
            halted_reg <= 1'b1;
            state_reg  <= S_HALT;
          end else begin
            retire_reg <= !(is_alu_op(op) || uses_imm(op));
            state_reg  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_alu_op(op) || op == OP_ADDI) begin
            alu_reg    <= alu_result;
            retire_reg <= 1'b1;
            state_reg  <= S_WB;
          end else if (op == OP_LW || op == OP_SW) begin
            alu_reg    <= alu_result;
            retire_reg <= (op == OP_SW);
            state_reg  <= S_MEM;
          end else begin
            if (is_branch(op) && taken) pc_reg <= branch_target;
            state_reg <= S_FETCH;
          end
        end
        S_MEM: begin
          if (op == OP_LW) begin
            mdr_reg    <= dmem[dmem_idx];
            retire_reg <= 1'b1;
            state_reg  <= S_WB;
          end else begin
            state_reg <= S_FETCH;
          end
        end
        S_WB: begin
          if (wb_en) regs[wb_dst] <= wb_val;
          state_reg <= S_FETCH;
        end
        S_HALT:  state_reg <= S_HALT;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // Data memory has no reset; a store lands only on its MEM edge.
  always_ff @(posedge clock) begin
    if (state_reg == S_MEM && op == OP_SW) dmem[dmem_idx] <= b_reg;
  end

  assign imem_addr = pc_reg;
  assign ir        = ir_reg;
  assign alu_out   = alu_reg;
  assign state     = state_reg;
  assign retire    = retire_reg;
  assign halted    = halted_reg;

endmodule
